// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: data-memory bus between the load/store unit (master) and
// the memory (slave).
//   req    : request valid, held until gnt
//   we     : 1 = write
//   addr   : word-aligned byte address
//   wdata  : lane-replicated store data
//   wmask  : byte-write mask
//   gnt    : slave accepts the request this cycle
//   rvalid : load data valid
//   rdata  : load data word
interface lsu_mem_ctrl_if #(parameter int WIDTH = 32);
  logic                 req;
  logic                 we;
  logic [WIDTH-1:0]     addr;
  logic [WIDTH-1:0]     wdata;
  logic [WIDTH/8-1:0]   wmask;
  logic                 gnt;
  logic                 rvalid;
  logic [WIDTH-1:0]     rdata;

  modport master (output req, we, addr, wdata, wmask, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, wmask, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store unit. Issues one word-aligned bus
// transaction per load/store, formats store masks/data and load results,
// and stalls the pipeline until the access completes (DONE).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   req_*             : MEM-stage request (valid, we, funct3, addr, wdata)
//   stall_o           : pipeline hold (combinational)
//   rdata_o           : formatted load data (registered)
//   rdata_valid_o     : one-cycle completion pulse
//   misalign_o        : one-cycle misaligned-access pulse
//   bus               : memory bus, master side
// Build option: define LSU_MISALIGN_TRAP_EN to complete misaligned H/W
// accesses without a bus transaction and flag them on misalign_o.
module lsu_mem_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             stall_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rdata_valid_o,
  output logic             misalign_o,
  lsu_mem_ctrl_if.master   bus
);

  localparam int NB = WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             we_q;
  logic [1:0]       size_q;   // 00 byte, 01 half, else word
  logic             uns_q;
  logic [1:0]       lane_q;
  logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic [NB-1:0]    wmask_q;

  logic [1:0]       req_size;
  logic [NB-1:0]    wmask_d;
  logic [WIDTH-1:0] wdata_d, fmt_d;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic             trap_d;
  logic             accept;

  // funct3[1:0] gives the size; undefined codes 011/110/111 fall into word.
  assign req_size = req_funct3[1:0];
  assign accept   = (state_q == S_IDLE) & req_valid;

  // Store formatting: replicate data so any lane the mask selects is valid.
  always_comb begin
    wmask_d = '1;
    wdata_d = req_wdata;
    case (req_size)
      2'b00: begin
        wmask_d = NB'(1) << req_addr[1:0];
        wdata_d = {NB{req_wdata[7:0]}};
      end
      2'b01: begin
        wmask_d = NB'(3) << {req_addr[1], 1'b0};
        wdata_d = {(NB/2){req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q;

  always_comb begin
    trap_d = 1'b0;
    case (req_size)
      2'b00:   trap_d = 1'b0;
      2'b01:   trap_d = req_addr[0];
      default: trap_d = |req_addr[1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         mis_q <= 1'b0;
    else if (accept) mis_q <= trap_d;
  end

  assign misalign_o = ~rst & (state_q == S_DONE) & mis_q;
`else
  assign trap_d     = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // Load formatting from the live bus word, captured on rvalid in WAIT.
  always_comb begin
    byte_sel = bus.rdata[{lane_q, 3'b000} +: 8];
    half_sel = bus.rdata[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   fmt_d = {{(WIDTH-8){~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   fmt_d = {{(WIDTH-16){~uns_q & half_sel[15]}}, half_sel};
      default: fmt_d = bus.rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid)  state_d = trap_d ? S_DONE : S_REQ;
      S_REQ:   if (bus.gnt)    state_d = we_q ? S_DONE : S_WAIT;
      S_WAIT:  if (bus.rvalid) state_d = S_DONE;
      S_DONE:                  state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        uns_q   <= req_funct3[2];
        lane_q  <= req_addr[1:0];
        addr_q  <= {req_addr[WIDTH-1:2], 2'b00};
        wdata_q <= wdata_d;
        wmask_q <= wmask_d;
      end
      if ((state_q == S_WAIT) && bus.rvalid) rdata_q <= fmt_d;
    end
  end

  // Combinational outputs are gated by rst so everything reads 0 in reset.
  assign stall_o       = ~rst & ((state_q == S_REQ) | (state_q == S_WAIT) | accept);
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = ~rst & (state_q == S_DONE);

  assign bus.req   = ~rst & (state_q == S_REQ);
  assign bus.we    = bus.req & we_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.wmask = wmask_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall_o, rdata_valid_o, misalign_o;
  logic [31:0] rdata_o;

  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.WIDTH(32)) bus();

  lsu_mem_ctrl #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .misalign_o    (misalign_o),
    .bus           (bus)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_rdata = 32'h0;

  // ---- reference model (RV32I semantics, plain arithmetic) ----
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * (a % 4))) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 4'(1 << (a % 4));
      3'd1:    return 4'(3 << (2 * ((a / 2) % 2)));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return (d & 32'hFF) * 32'h0101_0101;
      3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
    if (!TRAP_EN) return 1'b0;
    case (f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (a % 2) != 0;
      default:    return (a % 4) != 0;
    endcase
  endfunction

  // One access from its IDLE cycle (c=0) through DONE. gd = grant delay in
  // REQ cycles, rd = rvalid delay in WAIT cycles. Junk rvalid is driven in
  // REQ and DONE to show it is ignored there.
  task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rw,
                         input int gd, input int rd);
    bit          trap;
    int          done;
    logic [31:0] prev;
    trap = m_mis(f3, a);
    done = trap ? 1 : (we ? 2 + gd : 3 + gd + rd);
    prev = exp_rdata;
    if (!we && !trap) exp_rdata = m_load(f3, a, rw);
    for (int c = 0; c <= done; c++) begin
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      bus.gnt    = !trap && (c == 1 + gd);
      bus.rvalid = 1'b0;
      bus.rdata  = $urandom;
      if (!trap && c >= 1 && c <= 1 + gd) begin
        bus.rvalid = 1'($urandom % 2);
      end else if (!trap && !we && c >= 2 + gd && c < done) begin
        bus.rvalid = (c == done - 1);
        if (c == done - 1) bus.rdata = rw;
      end else if (c == done) begin
        bus.rvalid = 1'b1;
      end
      #1;
      checks++;
      if (stall_o !== (c < done)) begin
        errors++; $display("FAIL stall c%0d a=%h: got %b want %b", c, a, stall_o, c < done);
      end
      checks++;
      if (rdata_valid_o !== (c == done)) begin
        errors++; $display("FAIL rdata_valid c%0d a=%h: got %b want %b", c, a, rdata_valid_o, c == done);
      end
      checks++;
      if (misalign_o !== (trap && c == done)) begin
        errors++; $display("FAIL misalign c%0d a=%h: got %b want %b", c, a, misalign_o, trap && c == done);
      end
      checks++;
      if (bus.req !== (!trap && c >= 1 && c <= 1 + gd)) begin
        errors++; $display("FAIL bus_req c%0d a=%h: got %b want %b", c, a, bus.req, !trap && c >= 1 && c <= 1 + gd);
      end
      if (!trap && c >= 1 && c <= 1 + gd) begin
        checks++;
        if (bus.addr !== (a & ~32'h3)) begin
          errors++; $display("FAIL bus_addr c%0d: got %h want %h", c, bus.addr, a & ~32'h3);
        end
        checks++;
        if (bus.we !== we) begin
          errors++; $display("FAIL bus_we c%0d: got %b want %b", c, bus.we, we);
        end
        if (we) begin
          checks++;
          if (bus.wmask !== m_mask(f3, a)) begin
            errors++; $display("FAIL bus_wmask c%0d f3=%0d a=%h: got %b want %b", c, f3, a, bus.wmask, m_mask(f3, a));
          end
          checks++;
          if (bus.wdata !== m_wdata(f3, wd)) begin
            errors++; $display("FAIL bus_wdata c%0d f3=%0d: got %h want %h", c, f3, bus.wdata, m_wdata(f3, wd));
          end
        end
      end
      checks++;
      if (rdata_o !== ((c == done) ? exp_rdata : prev)) begin
        errors++; $display("FAIL rdata c%0d f3=%0d a=%h: got %h want %h", c, f3, a, rdata_o, (c == done) ? exp_rdata : prev);
      end
    end
    req_valid  = 1'b0;
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h1003; req_wdata = $urandom;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (stall_o !== 1'b0)       begin errors++; $display("FAIL rst_stall: got %b want 0", stall_o); end
    checks++; if (rdata_o !== 32'h0)      begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata_o); end
    checks++; if (rdata_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b want 0", rdata_valid_o); end
    checks++; if (misalign_o !== 1'b0)    begin errors++; $display("FAIL rst_misalign: got %b want 0", misalign_o); end
    checks++; if (bus.req !== 1'b0)       begin errors++; $display("FAIL rst_bus_req: got %b want 0", bus.req); end
    checks++; if (bus.we !== 1'b0)        begin errors++; $display("FAIL rst_bus_we: got %b want 0", bus.we); end
    checks++; if (bus.addr !== 32'h0)     begin errors++; $display("FAIL rst_bus_addr: got %h want 0", bus.addr); end
    checks++; if (bus.wdata !== 32'h0)    begin errors++; $display("FAIL rst_bus_wdata: got %h want 0", bus.wdata); end
    checks++; if (bus.wmask !== 4'h0)     begin errors++; $display("FAIL rst_bus_wmask: got %b want 0", bus.wmask); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.req !== 1'b1)        begin errors++; $display("FAIL post_rst_req: got %b want 1", bus.req); end
    checks++; if (bus.addr !== 32'h1000)   begin errors++; $display("FAIL post_rst_addr: got %h want 00001000", bus.addr); end
    checks++; if (stall_o !== 1'b1)        begin errors++; $display("FAIL post_rst_stall: got %b want 1", stall_o); end
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.req !== 1'b0)        begin errors++; $display("FAIL rst_in_req: got %b want 0", bus.req); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = '0;
    @(negedge clk);               // REQ
    bus.gnt = 1'b1;
    @(negedge clk);               // WAIT
    bus.gnt = 1'b0; req_valid = 1'b0; rst = 1'b1;
    #1;
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL rstwait_req: got %b want 0", bus.req); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rstwait_stall: got %b want 0", stall_o); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (rdata_valid_o !== 1'b0) begin errors++; $display("FAIL rstwait_rvalid i%0d: got %b want 0", i, rdata_valid_o); end
      checks++;
      if (rdata_o !== exp_rdata) begin errors++; $display("FAIL rstwait_rdata i%0d: got %h want %h", i, rdata_o, exp_rdata); end
      @(negedge clk);
      bus.rvalid = 1'b0;
    end
  endtask

  task automatic test_lb_sext();
    run_txn(1'b0, 3'd0, 32'h1003, 32'h0, 32'h80FF_FF7F, 0, 0);
    checks++;
    if (rdata_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_sext: got %h want ffffff80", rdata_o); end
  endtask

  task automatic test_sh_store();
    run_txn(1'b1, 3'd1, 32'h2002, 32'h0000_BEEF, 32'h0, 0, 0);
  endtask

  task automatic test_backpressure();
    run_txn(1'b0, 3'd2, 32'h3000, 32'h0, 32'hCAFE_F00D, 5, 0);
    run_txn(1'b1, 3'd0, 32'h3005, 32'h0000_00A5, 32'h0, 3, 0);
  endtask

  task automatic test_lw_misalign();
    run_txn(1'b0, 3'd2, 32'h3001, 32'h0, 32'h1234_5678, 0, 0);
    run_txn(1'b0, 3'd5, 32'h3003, 32'h0, 32'h8765_4321, 0, 1);
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 3'd2, 32'h0000_0100, 32'h0BAD_CAFE, 32'h0, 0, 0);
    run_txn(1'b0, 3'd4, 32'h0000_0102, 32'h0, 32'h00F0_0000, 0, 2);
    run_txn(1'b0, 3'd1, 32'h0000_0106, 32'h0, 32'h9ABC_0000, 1, 0);
  endtask

  task automatic test_random();
    logic [2:0] st_codes [6];
    logic [2:0] f3;
    bit         we;
    int         gap;
    st_codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 40; i++) begin
      we  = 1'($urandom % 2);
      f3  = we ? st_codes[$urandom % 6] : 3'($urandom % 8);
      run_txn(we, f3, $urandom, $urandom, $urandom, int'($urandom % 4), int'($urandom % 4));
      gap = int'($urandom % 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        #1;
        checks++;
        if (stall_o !== 1'b0 || rdata_valid_o !== 1'b0) begin
          errors++; $display("FAIL idle_gap i%0d: stall=%b rvalid=%b want 0 0", i, stall_o, rdata_valid_o);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_reset_in_wait();
    test_lb_sext();
    test_sh_store();
    test_backpressure();
    test_lw_misalign();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
